// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC register, imem addressing, 2-bit BHT branch prediction
module instruction_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h00000000,
    parameter int          BHT_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        branch_or_not,
    output logic [31:0] calculated_branch_address
);
    localparam int          IDX_W     = $clog2(BHT_ENTRIES);
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [31:0] NOP       = 32'h00000013;

    logic [31:0]      pc;
    logic [1:0]       bht [BHT_ENTRIES];
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [31:0]      pc_plus4;
    logic [31:0]      j_imm;
    logic [31:0]      b_imm;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic [31:0]      next_pc;
    logic             unused_update_bits;

    assign rd_idx    = pc[IDX_W+1:2];
    assign wr_idx    = update_pc[IDX_W+1:2];
    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;
    assign pc_out    = pc;
    assign j_imm = {{11{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                    imem_rdata[20], imem_rdata[30:21], 1'b0};
    assign b_imm = {{19{imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                    imem_rdata[30:25], imem_rdata[11:8], 1'b0};
    assign unused_update_bits = ^{update_pc[31:IDX_W+2], update_pc[1:0]};

    always_comb begin
        pred_taken  = 1'b0;
        pred_target = pc_plus4;
        if (imem_rdata[6:0] == OP_JAL) begin
            pred_taken  = 1'b1;
            pred_target = pc + j_imm;
        end else if (imem_rdata[6:0] == OP_BRANCH && bht[rd_idx][1]) begin
            pred_taken  = 1'b1;
            pred_target = pc + b_imm;
        end
    end

    // A flush replaces whatever was fetched with a NOP and points downstream at the fix-up PC.
    always_comb begin
        instruction_out           = imem_rdata;
        branch_or_not             = pred_taken;
        calculated_branch_address = pred_target;
        if (redirect_valid) begin
            instruction_out           = NOP;
            branch_or_not             = 1'b0;
            calculated_branch_address = redirect_pc;
        end
    end

    always_comb begin
        next_pc = pc_plus4;
        if (redirect_valid)
            next_pc = redirect_pc;
        else if (stall)
            next_pc = pc;
        else if (pred_taken)
            next_pc = pred_target;
    end

    // Training is independent of stall/redirect; a same-cycle read sees the old counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc <= RESET_PC;
            for (int i = 0; i < BHT_ENTRIES; i++)
                bht[i] <= 2'b01;
        end else begin
            pc <= next_pc;
            if (update_valid) begin
                if (update_taken && bht[wr_idx] != 2'b11)
                    bht[wr_idx] <= bht[wr_idx] + 2'b01;
                else if (!update_taken && bht[wr_idx] != 2'b00)
                    bht[wr_idx] <= bht[wr_idx] - 2'b01;
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;
    logic        clk = 1'b0;
    logic        resetn;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        branch_or_not;
    logic [31:0] calculated_branch_address;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] ADDI = 32'h00100093;
    localparam logic [31:0] JAL  = 32'h0100006F;
    localparam logic [31:0] BEQ  = 32'hFE000CE3;

    instruction_fetch #(.RESET_PC(32'h0), .BHT_ENTRIES(16)) dut (
        .clk(clk), .resetn(resetn), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc_out(pc_out),
        .instruction_out(instruction_out), .branch_or_not(branch_or_not),
        .calculated_branch_address(calculated_branch_address)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_pc(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        #1;
        step();
        redirect_valid = 1'b0;
        #1;
    endtask

    task automatic train(input logic taken);
        update_valid = 1'b1;
        update_pc    = 32'h20;
        update_taken = taken;
        step();
        update_valid = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        resetn = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        update_valid = 1'b0; update_pc = '0; update_taken = 1'b0; imem_rdata = ADDI;
        #2;
        check("reset_pc", pc_out, 32'h0);
        check("reset_imem_addr", imem_addr, 32'h0);
        @(posedge clk); #1;
        check("reset_hold_edge", pc_out, 32'h0);
        resetn = 1'b1;
        #1;
        check("addi_bor", {31'b0, branch_or_not}, 32'h0);
        check("addi_addr", calculated_branch_address, 32'h4);
        check("addi_instr", instruction_out, ADDI);
        step();
        check("addi_next_pc", pc_out, 32'h4);

        // JAL at 0x8
        redirect_valid = 1'b1; redirect_pc = 32'h8; #1;
        check("flush_instr", instruction_out, 32'h00000013);
        check("flush_addr", calculated_branch_address, 32'h8);
        step();
        redirect_valid = 1'b0;
        check("redirect_pc8", pc_out, 32'h8);
        imem_rdata = JAL; #1;
        check("jal_bor", {31'b0, branch_or_not}, 32'h1);
        check("jal_addr", calculated_branch_address, 32'h18);
        step();
        check("jal_next_pc", pc_out, 32'h18);

        // BHT training at 0x20 while stalled; first update overlaps the read
        goto_pc(32'h20);
        imem_rdata = BEQ; stall = 1'b1; #1;
        check("beq_init_bor", {31'b0, branch_or_not}, 32'h0);
        check("beq_init_addr", calculated_branch_address, 32'h24);
        update_valid = 1'b1; update_pc = 32'h20; update_taken = 1'b1; #1;
        check("beq_same_cycle_bor", {31'b0, branch_or_not}, 32'h0);
        step();
        update_valid = 1'b0; #1;
        check("beq_stall_pc", pc_out, 32'h20);
        check("beq_c10_bor", {31'b0, branch_or_not}, 32'h1);
        check("beq_c10_addr", calculated_branch_address, 32'h18);
        train(1'b1);
        check("beq_c11_bor", {31'b0, branch_or_not}, 32'h1);
        train(1'b0);
        check("beq_dec1_bor", {31'b0, branch_or_not}, 32'h1);
        train(1'b0);
        check("beq_dec2_bor", {31'b0, branch_or_not}, 32'h0);
        train(1'b0);
        check("beq_dec3_bor", {31'b0, branch_or_not}, 32'h0);
        train(1'b0);
        check("beq_sat0_bor", {31'b0, branch_or_not}, 32'h0);
        train(1'b1);
        check("beq_after_sat_inc_bor", {31'b0, branch_or_not}, 32'h0);
        train(1'b1);
        check("beq_c10_again_bor", {31'b0, branch_or_not}, 32'h1);
        stall = 1'b0; #1;
        step();
        check("beq_taken_next_pc", pc_out, 32'h18);

        // Stall hold at 0x30 while training the entry of 0x40
        goto_pc(32'h30);
        imem_rdata = ADDI; stall = 1'b1;
        update_valid = 1'b1; update_pc = 32'h40; update_taken = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("stall_pc", pc_out, 32'h30);
            check("stall_addr", calculated_branch_address, 32'h34);
            check("stall_instr", instruction_out, ADDI);
        end
        update_valid = 1'b0; stall = 1'b0;
        goto_pc(32'h40);
        imem_rdata = BEQ; #1;
        check("other_entry_trained_bor", {31'b0, branch_or_not}, 32'h1);
        check("other_entry_addr", calculated_branch_address, 32'h38);

        // Redirect beats stall
        imem_rdata = JAL; stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
        check("redir_instr", instruction_out, 32'h00000013);
        check("redir_bor", {31'b0, branch_or_not}, 32'h0);
        check("redir_addr", calculated_branch_address, 32'h100);
        step();
        redirect_valid = 1'b0; stall = 1'b0;
        check("redir_pc", pc_out, 32'h100);

        // Mid-run async reset at 0x40 clears pc and BHT
        goto_pc(32'h40);
        imem_rdata = BEQ; #1;
        check("pre_reset_bor", {31'b0, branch_or_not}, 32'h1);
        #2;
        resetn = 1'b0; #1;
        check("async_reset_pc", pc_out, 32'h0);
        check("async_reset_bht_bor", {31'b0, branch_or_not}, 32'h0);
        check("async_reset_addr", calculated_branch_address, 32'h4);
        resetn = 1'b1;
        step();
        check("post_reset_pc", pc_out, 32'h4);

        // Wrap at top of address space
        imem_rdata = ADDI;
        goto_pc(32'hFFFFFFFC);
        check("wrap_addr", calculated_branch_address, 32'h0);
        step();
        check("wrap_next_pc", pc_out, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
